// File: rtl/dic_set_ctrl.sv
// Keypad-driven set/alarm controller for the digital clock.
// Sequences time or alarm digit entry and runs the alarm flash/timeout logic.
module dic_set_ctrl #(
  parameter int unsigned ALARM_SECS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_strb,
  input  logic [7:0] key_code,
  input  logic       i_oneSecStrb,
  input  logic       alarm_match,
  output logic       dicRun,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic [3:0] ld_num,
  output logic       ld_alarm,
  output logic       dicSelectLEDdisp,
  output logic       alarm_en,
  output logic       alarm_flashing,
  output logic       key_err,
  output logic [2:0] set_state
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    TSET_MT = 3'd1,
    TSET_MO = 3'd2,
    TSET_ST = 3'd3,
    TSET_SO = 3'd4,
    ASET_MT = 3'd5,
    ASET_MO = 3'd6,
    ASET_ST = 3'd7
  } state_e;

  localparam logic [7:0] KEY_S   = 8'h73;
  localparam logic [7:0] KEY_A   = 8'h61;
  localparam logic [7:0] KEY_E   = 8'h65;
  localparam logic [7:0] KEY_N   = 8'h6E;
  localparam logic [7:0] KEY_ESC = 8'h1B;
  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SECS);

  state_e     state_q, state_d;
  logic       aset_q, aset_d;
  logic       run_q, run_d;
  logic       ld_mt_q, ld_mt_d;
  logic       ld_mo_q, ld_mo_d;
  logic       ld_st_q, ld_st_d;
  logic       ld_so_q, ld_so_d;
  logic [3:0] ld_num_q, ld_num_d;
  logic       ld_alarm_q, ld_alarm_d;
  logic       sel_q, sel_d;
  logic       alarm_en_q, alarm_en_d;
  logic       flash_q, flash_d;
  logic       key_err_q, key_err_d;
  logic [7:0] sec_cnt_q, sec_cnt_d;
  logic       match_prev_q, match_prev_d;

  logic       is_digit;
  logic [3:0] digit;
  logic       is_tens;
  logic       in_aset;
  logic       key_live;
  logic       alarm_start;

  always_comb begin
    is_digit    = (key_code >= 8'h30) && (key_code <= 8'h39);
    digit       = key_code[3:0];
    is_tens     = (state_q == TSET_MT) || (state_q == TSET_ST) ||
                  (state_q == ASET_MT) || (state_q == ASET_ST);
    in_aset     = (state_q == ASET_MT) || (state_q == ASET_MO) ||
                  (state_q == ASET_ST) || ((state_q == TSET_SO) && aset_q);
    // A key pressed while the alarm flashes only dismisses the alarm.
    key_live    = key_strb && !flash_q;
    alarm_start = alarm_en_q && alarm_match && !match_prev_q && !flash_q;
  end

  always_comb begin
    state_d      = state_q;
    aset_d       = aset_q;
    run_d        = run_q;
    ld_mt_d      = 1'b0;
    ld_mo_d      = 1'b0;
    ld_st_d      = 1'b0;
    ld_so_d      = 1'b0;
    ld_num_d     = ld_num_q;
    ld_alarm_d   = ld_alarm_q;
    sel_d        = 1'b0;
    alarm_en_d   = alarm_en_q;
    flash_d      = flash_q;
    key_err_d    = 1'b0;
    sec_cnt_d    = sec_cnt_q;
    match_prev_d = alarm_match;

    if (key_live) begin
      if (key_code == KEY_N) begin
        sel_d = 1'b1;
      end else if (state_q == RUN) begin
        if (key_code == KEY_S) begin
          state_d = TSET_MT;
          aset_d  = 1'b0;
          run_d   = 1'b0;
        end else if (key_code == KEY_A) begin
          state_d = ASET_MT;
          aset_d  = 1'b1;
        end else if (key_code == KEY_E) begin
          alarm_en_d = !alarm_en_q;
        end
      end else if (key_code == KEY_ESC) begin
        state_d = RUN;
        aset_d  = 1'b0;
        run_d   = 1'b1;
      end else if (is_digit) begin
        if (is_tens && (digit > 4'd5)) begin
          key_err_d = 1'b1;
        end else begin
          ld_num_d   = digit;
          ld_alarm_d = in_aset;
          case (state_q)
            TSET_MT: begin ld_mt_d = 1'b1; state_d = TSET_MO; end
            TSET_MO: begin ld_mo_d = 1'b1; state_d = TSET_ST; end
            TSET_ST: begin ld_st_d = 1'b1; state_d = TSET_SO; end
            ASET_MT: begin ld_mt_d = 1'b1; state_d = ASET_MO; end
            ASET_MO: begin ld_mo_d = 1'b1; state_d = ASET_ST; end
            ASET_ST: begin ld_st_d = 1'b1; state_d = TSET_SO; end
            TSET_SO: begin
              ld_so_d = 1'b1;
              state_d = RUN;
              aset_d  = 1'b0;
              run_d   = 1'b1;
            end
            default: state_d = RUN;
          endcase
        end
      end else begin
        key_err_d = 1'b1;
      end
    end

    // Key dismissal wins over the seconds timeout in the same cycle.
    if (key_strb && flash_q) begin
      flash_d = 1'b0;
    end else if (flash_q && i_oneSecStrb) begin
      sec_cnt_d = sec_cnt_q + 8'd1;
      if (sec_cnt_d == ALARM_LIMIT) flash_d = 1'b0;
    end
    if (alarm_start) begin
      flash_d   = 1'b1;
      sec_cnt_d = 8'd0;
    end
    if (!alarm_en_d) flash_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      aset_q       <= 1'b0;
      run_q        <= 1'b1;
      ld_mt_q      <= 1'b0;
      ld_mo_q      <= 1'b0;
      ld_st_q      <= 1'b0;
      ld_so_q      <= 1'b0;
      ld_num_q     <= 4'd0;
      ld_alarm_q   <= 1'b0;
      sel_q        <= 1'b0;
      alarm_en_q   <= 1'b0;
      flash_q      <= 1'b0;
      key_err_q    <= 1'b0;
      sec_cnt_q    <= 8'd0;
      match_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      aset_q       <= aset_d;
      run_q        <= run_d;
      ld_mt_q      <= ld_mt_d;
      ld_mo_q      <= ld_mo_d;
      ld_st_q      <= ld_st_d;
      ld_so_q      <= ld_so_d;
      ld_num_q     <= ld_num_d;
      ld_alarm_q   <= ld_alarm_d;
      sel_q        <= sel_d;
      alarm_en_q   <= alarm_en_d;
      flash_q      <= flash_d;
      key_err_q    <= key_err_d;
      sec_cnt_q    <= sec_cnt_d;
      match_prev_q <= match_prev_d;
    end
  end

  assign dicRun           = run_q;
  assign ldMtens          = ld_mt_q;
  assign ldMones          = ld_mo_q;
  assign ldStens          = ld_st_q;
  assign ldSones          = ld_so_q;
  assign ld_num           = ld_num_q;
  assign ld_alarm         = ld_alarm_q;
  assign dicSelectLEDdisp = sel_q;
  assign alarm_en         = alarm_en_q;
  assign alarm_flashing   = flash_q;
  assign key_err          = key_err_q;
  assign set_state        = state_q;

endmodule

// File: tb/tb_dic_set_ctrl.sv
// Bench for dic_set_ctrl: directed vector table, hand-written alarm/reset
// sequences, then random keys checked against a digit-index reference model.
module tb_dic_set_ctrl;

  localparam int ALARM_SECS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_strb;
  logic [7:0] key_code;
  logic       i_oneSecStrb;
  logic       alarm_match;
  logic       dicRun;
  logic       ldMtens, ldMones, ldStens, ldSones;
  logic [3:0] ld_num;
  logic       ld_alarm;
  logic       dicSelectLEDdisp;
  logic       alarm_en;
  logic       alarm_flashing;
  logic       key_err;
  logic [2:0] set_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dic_set_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk),
    .rst(rst),
    .key_strb(key_strb),
    .key_code(key_code),
    .i_oneSecStrb(i_oneSecStrb),
    .alarm_match(alarm_match),
    .dicRun(dicRun),
    .ldMtens(ldMtens),
    .ldMones(ldMones),
    .ldStens(ldStens),
    .ldSones(ldSones),
    .ld_num(ld_num),
    .ld_alarm(ld_alarm),
    .dicSelectLEDdisp(dicSelectLEDdisp),
    .alarm_en(alarm_en),
    .alarm_flashing(alarm_flashing),
    .key_err(key_err),
    .set_state(set_state)
  );

  // Reference model: mode 0=run, 1=time entry, 2=alarm entry; idx = digit position.
  int         m_mode, m_idx, m_cnt, m_num;
  logic       m_run, m_lda, m_sel, m_en, m_flash, m_err, m_prev;
  logic [3:0] m_ld;

  task automatic modelStep(input logic r, input logic ks, input logic [7:0] kc,
                           input logic sec, input logic match);
    logic en_before, flashed;
    int d;
    if (r) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_num = 0;
      m_run = 1; m_lda = 0; m_sel = 0; m_en = 0; m_flash = 0; m_err = 0;
      m_prev = 0; m_ld = 4'b0000;
      return;
    end
    m_sel = 0; m_err = 0; m_ld = 4'b0000;
    en_before = m_en;
    flashed   = m_flash;
    if (ks && !flashed) begin
      if (kc == 8'h6E) m_sel = 1;
      else if (m_mode == 0) begin
        if (kc == 8'h73) begin m_mode = 1; m_idx = 0; m_run = 0; end
        else if (kc == 8'h61) begin m_mode = 2; m_idx = 0; end
        else if (kc == 8'h65) m_en = !m_en;
      end else if (kc == 8'h1B) begin
        m_mode = 0; m_run = 1;
      end else if (kc >= 8'h30 && kc <= 8'h39) begin
        d = int'(kc) - 48;
        if ((m_idx % 2 == 0) && d > 5) m_err = 1;
        else begin
          m_ld[3 - m_idx] = 1'b1;
          m_num = d;
          m_lda = (m_mode == 2);
          m_idx++;
          if (m_idx == 4) begin m_mode = 0; m_run = 1; end
        end
      end else m_err = 1;
    end
    if (ks && flashed) m_flash = 0;
    else if (flashed && sec) begin
      m_cnt++;
      if (m_cnt == ALARM_SECS) m_flash = 0;
    end
    if (en_before && match && !m_prev && !flashed) begin
      m_flash = 1; m_cnt = 0;
    end
    if (!m_en) m_flash = 0;
    m_prev = match;
  endtask

  function automatic int modelState();
    if (m_mode == 0) return 0;
    if (m_mode == 1) return 1 + m_idx;
    return (m_idx == 3) ? 4 : 5 + m_idx;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " set_state"}, set_state, modelState());
    checkOutput({tag, " dicRun"}, dicRun, m_run);
    checkOutput({tag, " ld"}, {ldMtens, ldMones, ldStens, ldSones}, m_ld);
    checkOutput({tag, " ld_num"}, ld_num, m_num);
    checkOutput({tag, " ld_alarm"}, ld_alarm, m_lda);
    checkOutput({tag, " sel"}, dicSelectLEDdisp, m_sel);
    checkOutput({tag, " alarm_en"}, alarm_en, m_en);
    checkOutput({tag, " flashing"}, alarm_flashing, m_flash);
    checkOutput({tag, " key_err"}, key_err, m_err);
  endtask

  // One clock of stimulus; outputs are sampled 1ns after the active edge.
  task automatic applyStimulus(input logic r, input logic ks, input logic [7:0] kc,
                               input logic sec, input logic match);
    @(negedge clk);
    rst = r; key_strb = ks; key_code = kc; i_oneSecStrb = sec; alarm_match = match;
    @(posedge clk);
    #1;
    modelStep(r, ks, kc, sec, match);
  endtask

  typedef struct {
    logic       ks;
    logic [7:0] kc;
    logic [2:0] st;
    logic       run;
    logic [3:0] ld;
    logic [3:0] num;
    logic       lda;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] pickKey();
    case ($urandom_range(0, 19))
      0, 1:   return 8'h73;
      2:      return 8'h61;
      3:      return 8'h65;
      4:      return 8'h6E;
      5:      return 8'h1B;
      6:      return 8'($urandom_range(0, 255));
      default: return 8'(8'h30 + $urandom_range(0, 9));
    endcase
  endfunction

  initial begin
    logic match_r;
    rst = 1'b1; key_strb = 1'b0; key_code = 8'h00; i_oneSecStrb = 1'b0; alarm_match = 1'b0;

    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(1, 1, 8'h73, 1, 1);
    checkOutput("reset state", set_state, 0);
    checkOutput("reset dicRun", dicRun, 1);
    checkOutput("reset strobes", {ldMtens, ldMones, ldStens, ldSones, dicSelectLEDdisp, key_err}, 0);
    checkOutput("reset alarm", {alarm_en, alarm_flashing, ld_alarm}, 0);
    checkOutput("reset ld_num", ld_num, 0);

    vecs.push_back('{1'b1, 8'h73, 3'd1, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h31, 3'd2, 1'b0, 4'b1000, 4'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h32, 3'd3, 1'b0, 4'b0100, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 3'd4, 1'b0, 4'b0010, 4'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h34, 3'd0, 1'b1, 4'b0001, 4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h73, 3'd0, 1'b1, 4'b0000, 4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h73, 3'd1, 1'b0, 4'b0000, 4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h37, 3'd1, 1'b0, 4'b0000, 4'd4, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h35, 3'd2, 1'b0, 4'b1000, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h1B, 3'd0, 1'b1, 4'b0000, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h61, 3'd5, 1'b1, 4'b0000, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h30, 3'd6, 1'b1, 4'b1000, 4'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h36, 3'd7, 1'b1, 4'b0100, 4'd6, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 3'd4, 1'b1, 4'b0010, 4'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h30, 3'd0, 1'b1, 4'b0001, 4'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h1B, 3'd0, 1'b1, 4'b0000, 4'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h78, 3'd0, 1'b1, 4'b0000, 4'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h73, 3'd1, 1'b0, 4'b0000, 4'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h32, 3'd2, 1'b0, 4'b1000, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h7A, 3'd2, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h1B, 3'd0, 1'b1, 4'b0000, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h73, 3'd1, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].ks, vecs[i].kc, 0, 0);
      checkOutput($sformatf("vec%0d state", i), set_state, vecs[i].st);
      checkOutput($sformatf("vec%0d dicRun", i), dicRun, vecs[i].run);
      checkOutput($sformatf("vec%0d ld", i), {ldMtens, ldMones, ldStens, ldSones}, vecs[i].ld);
      checkOutput($sformatf("vec%0d ld_num", i), ld_num, vecs[i].num);
      checkOutput($sformatf("vec%0d ld_alarm", i), ld_alarm, vecs[i].lda);
      checkOutput($sformatf("vec%0d key_err", i), key_err, vecs[i].err);
      checkOutput($sformatf("vec%0d sel/alarm", i), {dicSelectLEDdisp, alarm_en, alarm_flashing}, 0);
    end

    // Reset in the middle of a time-set sequence, with a digit key pending.
    applyStimulus(1, 1, 8'h33, 0, 0);
    checkOutput("midrst state", set_state, 0);
    checkOutput("midrst dicRun", dicRun, 1);
    checkOutput("midrst ld_num", ld_num, 0);
    applyStimulus(0, 0, 8'h33, 0, 0);
    checkOutput("postrst strobes", {ldMtens, ldMones, ldStens, ldSones, key_err}, 0);
    checkOutput("postrst state", set_state, 0);

    // 'n' inside TSET_MO
    applyStimulus(0, 1, 8'h73, 0, 0);
    applyStimulus(0, 1, 8'h31, 0, 0);
    applyStimulus(0, 1, 8'h6E, 0, 0);
    checkOutput("n sel pulse", dicSelectLEDdisp, 1);
    checkOutput("n state", set_state, 2);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("n sel drop", dicSelectLEDdisp, 0);
    applyStimulus(0, 1, 8'h1B, 0, 0);
    checkOutput("esc state", set_state, 0);

    // Alarm arm, trigger, timeout, no retrigger while held, dismiss by key.
    applyStimulus(0, 1, 8'h65, 0, 0);
    checkOutput("arm en", alarm_en, 1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("trigger", alarm_flashing, 1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("sec1", alarm_flashing, 1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("sec2", alarm_flashing, 1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("sec3 timeout", alarm_flashing, 0);
    applyStimulus(0, 0, 8'h00, 1, 1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("held no retrigger", alarm_flashing, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("retrigger", alarm_flashing, 1);
    applyStimulus(0, 1, 8'h73, 1, 1);
    checkOutput("dismiss flash", alarm_flashing, 0);
    checkOutput("dismiss state", set_state, 0);
    checkOutput("dismiss dicRun", dicRun, 1);
    checkOutput("dismiss key_err", key_err, 0);
    applyStimulus(0, 1, 8'h73, 0, 1);
    checkOutput("after dismiss s", set_state, 1);
    applyStimulus(0, 1, 8'h1B, 0, 0);
    checkModel("directed end");

    // Random phase against the reference model.
    match_r = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) match_r = !match_r;
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), pickKey(),
                    ($urandom_range(0, 3) == 0), match_r);
      checkModel($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dic_set_ctrl.md
DIC_SET_CTRL -- requirements
Module: dic_set_ctrl

Interface
REQ-001 Parameter ALARM_SECS, default 30: number of i_oneSecStrb pulses after which a flashing alarm self-clears (range 1-255).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 key_strb  input  1  one-cycle strobe; key_code is valid this cycle.
REQ-005 key_code  input  8  ASCII code of the pressed key.
REQ-006 i_oneSecStrb  input  1  one-cycle strobe, once per second.
REQ-007 alarm_match  input  1  level, 1 while current time equals the alarm time.
REQ-008 dicRun  output  1  1 = clock counts, 0 = clock frozen.
REQ-009 ldMtens, ldMones, ldStens, ldSones  output  1 each  one-cycle digit-load strobes.
REQ-010 ld_num  output  4  digit value that accompanies a load strobe.
REQ-011 ld_alarm  output  1  qualifies load strobes: 0 = time counters, 1 = alarm registers.
REQ-012 dicSelectLEDdisp  output  1  one-cycle strobe that advances the LED digit selector.
REQ-013 alarm_en  output  1  alarm armed.
REQ-014 alarm_flashing  output  1  alarm is currently signalling.
REQ-015 key_err  output  1  one-cycle strobe flagging a rejected key.
REQ-016 set_state  output  3  current FSM state encoding, for debug.

Function
REQ-017 FSM states: RUN=0, TSET_MT=1, TSET_MO=2, TSET_ST=3, TSET_SO=4, ASET_MT=5, ASET_MO=6, ASET_ST=7.
- ASET_SO reuses TSET_SO with the internal flag aset=1.
- set_state reports 4 while in that shared state.
REQ-018 All outputs are registered; every response appears on the first rising edge after the key_strb cycle (latency 1).
REQ-019 key_code is ignored in any cycle where key_strb=0.
REQ-020 RUN, key 's' (0x73): go to TSET_MT, dicRun<=0.
REQ-021 RUN, key 'a' (0x61): go to ASET_MT; dicRun stays 1.
REQ-022 RUN, key 'e' (0x65): toggle alarm_en.
REQ-023 Any state, key 'n' (0x6E): pulse dicSelectLEDdisp; no state change.
REQ-024 Digit keys 0x30-0x39 have value d = key_code[3:0].
REQ-025 Tens states (xSET_MT, xSET_ST):
- d<=5: pulse the matching ld strobe, ld_num<=d, advance to the next state.
- d>5: pulse key_err, stay in the current state.
REQ-026 Ones states (xSET_MO, xSET_SO): any d 0-9 loads and advances.
REQ-027 ld_alarm equals 1 for strobes issued in the ASET sequence and 0 in the TSET sequence.
REQ-028 ld_num holds its last value between strobes.
REQ-029 After the SO load, go to RUN and set dicRun<=1, for both sequences.
REQ-030 Key ESC (0x1B) in any set state: go to RUN, dicRun<=1.
- Digits already loaded are kept.
- No load strobe is issued.
REQ-031 Key ESC in RUN is ignored.
REQ-032 In a set state, any key other than a digit, 'n' or ESC pulses key_err and causes no state change.
REQ-033 In RUN, keys other than 's', 'a', 'e', 'n' are ignored, with no key_err.
REQ-034 Alarm start: when alarm_en=1 and alarm_match rises (registered 0->1), and alarm_flashing=0:
- set alarm_flashing<=1;
- clear the seconds counter.
REQ-035 Alarm timing:
- While flashing, each i_oneSecStrb increments an 8-bit counter.
- The i_oneSecStrb that brings the count to ALARM_SECS clears alarm_flashing.
REQ-036 Any key_strb while flashing clears alarm_flashing and is consumed: no other action, no key_err.
- This takes priority over the seconds timeout in the same cycle.
REQ-037 Clearing alarm_en also clears alarm_flashing.
- A match that is still held high does not retrigger until it falls and rises again.
REQ-038 Alarm logic runs in every FSM state.

Reset
REQ-039 While rst=1 on a clock edge, the block takes these values:
- state RUN, dicRun=1, ld_num=0, ld_alarm=0;
- all strobes 0, alarm_en=0, alarm_flashing=0;
- counter 0, match history 0.
REQ-040 A reset in mid-sequence abandons the sequence; no pending strobe is issued afterwards.

Verification
REQ-041 Time set: 's','1','2','3','4' -> dicRun=0, then:
- strobes ldMtens/1, ldMones/2, ldStens/3, ldSones/4, all with ld_alarm=0;
- final state RUN, dicRun=1.
REQ-042 Digit rejection: in TSET_MT, '7' -> key_err pulse, state stays 1; then '5' -> ldMtens with ld_num=5.
REQ-043 Alarm set: 'a','0','6','3','0' -> four strobes with ld_alarm=1 and values 0,6,3,0; dicRun=1 throughout.
REQ-044 Abort and reset: 's','2',ESC -> RUN with dicRun=1, only ldMtens issued; 's' then rst mid-sequence -> RUN with all outputs at reset values.
REQ-045 Alarm timeout (ALARM_SECS=3): 'e', alarm_match rises -> alarm_flashing=1; 3 i_oneSecStrb -> 0; match held high -> no retrigger.
REQ-046 Alarm dismiss: flashing, press 's' -> alarm_flashing=0 and state stays RUN; 'n' in TSET_MO -> dicSelectLEDdisp pulse, state stays 2.
